// File: rtl/uart_reg_ctrl.sv
// uart_reg_ctrl: byte-framed command sequencer between an osdvu-style uart
// core and a bank of 8-bit configuration registers. Frames are 'W' addr data
// (answered 'K'), 'R' addr (answered with the register value); anything else
// is answered '?'. Exactly one response byte is scheduled per frame.
module uart_reg_ctrl #(
    parameter int unsigned NREGS       = 8,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned TIMEOUT_CYC = 1200000,
    parameter int unsigned TXSTART_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 received,
    input  logic [7:0]           rx_byte,
    input  logic                 recv_error,
    input  logic                 is_transmitting,
    output logic                 transmit,
    output logic [7:0]           tx_byte,
    output logic [8*NREGS-1:0]   regs_flat,
    output logic                 wr_strobe,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic                 busy
);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_BAD  = 8'h3F;

    localparam int unsigned CNT_MAX = (TIMEOUT_CYC > TXSTART_CYC) ? TIMEOUT_CYC : TXSTART_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = $clog2(8 * NREGS);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        EXEC,
        TX_REQ,
        TX_START,
        TX_END
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 op_write;
    logic                 addr_ok;
    logic [ADDR_W-1:0]    addr_q;
    logic [7:0]           data_q;
    logic [ADDR_W-1:0]    wr_addr_q;
    logic [8*NREGS-1:0]   regs_q;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     reg_idx;
    logic                 rx_ok;
    logic                 is_op_w;
    logic                 is_op_r;
    logic                 timeout_hit;
    logic                 txstart_hit;
    logic                 wr_en;

    // Decode of the incoming byte and the shared wait counter limits
    always_comb begin
        rx_ok       = received && !recv_error;
        is_op_w     = (rx_byte == OP_WRITE);
        is_op_r     = (rx_byte == OP_READ);
        timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));
        txstart_hit = (cnt == CNT_W'(TXSTART_CYC - 1));
        reg_idx     = IDX_W'({addr_q, 3'b000});
        wr_en       = (state == EXEC) && op_write && addr_ok;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a framing error always wins over a same-cycle byte
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (rx_ok) begin
                    state_next = (is_op_w || is_op_r) ? GET_ADDR : TX_REQ;
                end
            end
            GET_ADDR: begin
                if (recv_error) begin
                    state_next = IDLE;
                end else if (received) begin
                    state_next = op_write ? GET_DATA : EXEC;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            GET_DATA: begin
                if (recv_error) begin
                    state_next = IDLE;
                end else if (received) begin
                    state_next = EXEC;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            EXEC: begin
                state_next = TX_REQ;
            end
            TX_REQ: begin
                if (!is_transmitting) begin
                    state_next = TX_START;
                end
            end
            TX_START: begin
                if (is_transmitting) begin
                    state_next = TX_END;
                end else if (txstart_hit) begin
                    state_next = IDLE;
                end
            end
            TX_END: begin
                if (!is_transmitting) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; wr_addr shows the live address during EXEC
    always_comb begin
        busy      = (state != IDLE);
        transmit  = (state == TX_REQ) && !is_transmitting;
        wr_strobe = wr_en;
        wr_addr   = wr_en ? addr_q : wr_addr_q;
        regs_flat = regs_q;
    end

    // Wait counter: byte gap inside a frame, then transmit-start window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            unique case (state)
                GET_ADDR, GET_DATA: cnt <= (received || recv_error) ? '0 : cnt + CNT_W'(1);
                TX_START:           cnt <= cnt + CNT_W'(1);
                default:            cnt <= '0;
            endcase
        end
    end

    // Frame capture, register bank update and response byte selection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_write  <= 1'b0;
            addr_ok   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_addr_q <= '0;
            regs_q    <= '0;
            tx_byte   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rx_ok) begin
                        op_write <= is_op_w;
                        if (!(is_op_w || is_op_r)) begin
                            tx_byte <= RSP_BAD;
                        end
                    end
                end
                GET_ADDR: begin
                    if (rx_ok) begin
                        addr_q  <= rx_byte[ADDR_W-1:0];
                        addr_ok <= (32'(rx_byte) < NREGS);
                    end
                end
                GET_DATA: begin
                    if (rx_ok) begin
                        data_q <= rx_byte;
                    end
                end
                EXEC: begin
                    if (!addr_ok) begin
                        tx_byte <= RSP_BAD;
                    end else if (op_write) begin
                        regs_q[reg_idx +: 8] <= data_q;
                        wr_addr_q            <= addr_q;
                        tx_byte              <= RSP_OK;
                    end else begin
                        tx_byte <= regs_q[reg_idx +: 8];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
